booth_mul_seq: RTL and testbench
================================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16x16 signed, product width at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  synchronous abort; returns the block to IDLE from any state.
REQ-005 in_valid  input  1  operand pair a/b offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  16  multiplicand, two's complement.
REQ-008 b  input  16  multiplier, two's complement, radix-4 Booth recoded.
REQ-009 out_valid  output  1  prod holds a finished result.
REQ-010 out_ready  input  1  consumer accepts prod.
REQ-011 prod  output  32  signed product a*b.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, CALC and DONE, state-encoded in registers.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); both registered-state decodes, no combinational path from inputs.
REQ-015 Input accept occurs on an edge where in_valid && in_ready: latch a and b, clear accumulator to 0, clear digit counter cnt (3 bits) to 0, go to CALC.
REQ-016 in_valid, a and b SHALL be ignored in CALC and DONE; latched operands SHALL not change until the next accept.
REQ-017 In CALC, each edge SHALL process digit i=cnt: code={b[2i+1],b[2i],b[2i-1]}, b[-1]=0.
REQ-018 Digit decode: 000/111 -> 0; 001/010 -> +a; 011 -> +2a; 100 -> -2a; 101/110 -> -a; negative when code[2]=1 and not zero.
REQ-019 Partial product SHALL be the decoded value sign-extended to 32 bits, then shifted left by 2i; negation is two's complement (invert plus 1) in 32 bits.
REQ-020 Accumulator update SHALL be acc <= acc + pp modulo 2^32; cnt increments by 1.
REQ-021 On the edge processing cnt==7 the state SHALL go to DONE; exactly 8 accumulation edges per operation.
REQ-022 Latency: out_valid SHALL rise 8 cycles after the accept edge; throughput one operation per 10 cycles minimum (accept, 8 CALC, 1 DONE).
REQ-023 prod SHALL be driven from the accumulator and be stable while out_valid && !out_ready.
REQ-024 In DONE, out_ready high SHALL return state to IDLE at that edge; in_ready is low in DONE, so a new accept cannot occur in the same cycle as output handshake.
REQ-025 clear high SHALL force IDLE at the next edge from any state, zero acc and cnt, discard any result without an output handshake; clear has priority over all other events.
REQ-026 Extreme operands (a or b = -32768) SHALL produce exact results; no overflow exists in 32 bits.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, acc=0, cnt=0, latched a/b=0.
REQ-028 During and after reset: in_ready=1, out_valid=0, busy=0, prod=0x00000000.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abort the operation; no result is produced after release.

Verification
REQ-030 a=3, b=5, out_ready=1 -> out_valid exactly 8 cycles after accept, prod=0x0000000F, then in_ready=1 next cycle.
REQ-031 a=-32768, b=-32768 -> prod=0x40000000; a=0x7FFF, b=0x8000 -> prod=0xC0008000.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE, in_valid=1 with new operands -> prod unchanged, in_ready=0, busy=1; out_ready=1 -> IDLE, then new operands accepted.
REQ-033 rst_n low at cnt=4 of a=100, b=200 -> all outputs at reset values; after release a=-1, b=-1 -> prod=0x00000001.
REQ-034 clear=1 in DONE with out_ready=0 -> next cycle out_valid=0, in_ready=1, prod=0, no handshake recorded.
REQ-035 Random 10k signed pairs with random out_ready stalls -> every prod equals 32-bit signed a*b, in-order, none lost or duplicated.

Source files
------------

// File: rtl/booth_mul_seq_if.sv
// Operand/result handshake bundle for booth_mul_seq.
// master: operand producer / result consumer (drives a, b, in_valid, out_ready, clear).
// slave : the multiplier (drives in_ready, out_valid, prod, busy).
interface booth_mul_seq_if;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;
  logic        busy;

  modport master (
    output clear, in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  clear, in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, busy
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential 16x16 signed multiplier using radix-4 Booth recoding.
// One recoded digit of b is accumulated per cycle: accept, 8 CALC cycles, then DONE
// holds the 32-bit product until the consumer takes it.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - booth_mul_seq_if.slave: clear, in_valid/in_ready/a/b,
//           out_valid/out_ready/prod, busy
module booth_mul_seq (
  input logic            clk,
  input logic            rst_n,
  booth_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc_q;
  logic [2:0]  cnt_q;

  logic [16:0] b_ext;
  logic [4:0]  bit_idx;
  logic [2:0]  code;
  logic [31:0] a_ext;
  logic [31:0] mag;
  logic [31:0] pp_unsh;
  logic [31:0] pp;

  // Partial product for digit cnt_q.
  always_comb begin
    b_ext   = {b_q, 1'b0};  // b[-1] = 0
    bit_idx = {1'b0, cnt_q, 1'b0};
    code    = b_ext[bit_idx +: 3];
    a_ext   = {{16{a_q[15]}}, a_q};
    case (code)
      3'b001, 3'b010, 3'b101, 3'b110: mag = a_ext;
      3'b011, 3'b100:                 mag = a_ext << 1;
      default:                        mag = '0;
    endcase
    // 111 decodes to zero, so it must not take the negate path.
    pp_unsh = (code[2] && (code != 3'b111)) ? (~mag + 32'd1) : mag;
    pp      = pp_unsh << bit_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.clear) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_q + pp;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= StDone;
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.prod      = acc_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed self-checking bench for booth_mul_seq.
module tb_booth_mul_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   hs_cnt;

  booth_mul_seq_if bus ();

  booth_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output handshakes seen on the bus.
  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair while idle; returns after the accept edge.
  task automatic start(input logic [15:0] av, input logic [15:0] bv);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  // Full operation: accept, check latency and product, stall, handshake.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] exp, input int stall);
    int cyc;
    bus.out_ready = 1'b0;
    start(av, bv);
    wait_done(cyc);
    chk({tag, "_lat"}, cyc, 32'd8);
    chk({tag, "_prod"}, bus.prod, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk1({tag, "_stall_ov"}, bus.out_valid, 1'b1);
      chk({tag, "_stall_prod"}, bus.prod, exp);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk1({tag, "_ir_after"}, bus.in_ready, 1'b1);
    chk1({tag, "_ov_after"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    logic signed [15:0] ra;
    logic signed [15:0] rb;
    logic signed [31:0] rexp;
    int                 cyc;
    int                 hs_before;

    n_cmp         = 0;
    n_err         = 0;
    hs_cnt        = 0;
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_prod", bus.prod, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic product, latency 8, in_ready back the cycle after the handshake.
    do_op("mul_3x5", 16'd3, 16'd5, 32'h0000000F, 0);

    // Extremes.
    do_op("mul_min_min", 16'h8000, 16'h8000, 32'h40000000, 0);
    do_op("mul_max_min", 16'h7FFF, 16'h8000, 32'hC0008000, 0);
    do_op("mul_max_max", 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1);
    do_op("mul_min_1", 16'h8000, 16'h0001, 32'hFFFF8000, 0);
    do_op("mul_m7_9", 16'hFFF9, 16'h0009, 32'hFFFFFFC1, 2);
    do_op("mul_1234_m5678", 16'd1234, -16'sd5678, 32'hFF951644, 0);
    do_op("mul_0_x", 16'h0000, 16'h1234, 32'h00000000, 0);

    // Backpressure in DONE with new operands offered.
    bus.out_ready = 1'b0;
    start(16'd3, 16'd5);
    wait_done(cyc);
    chk("bp_lat", cyc, 32'd8);
    bus.in_valid = 1'b1;
    bus.a        = 16'd11;
    bus.b        = 16'd13;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_prod", bus.prod, 32'h0000000F);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
      chk1("bp_busy", bus.busy, 1'b1);
      chk1("bp_out_valid", bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk1("bp_idle", bus.in_ready, 1'b1);
    tick();  // accept 11 * 13 held on the bus
    bus.in_valid = 1'b0;
    chk1("bp_new_busy", bus.busy, 1'b1);
    wait_done(cyc);
    chk("bp_new_lat", cyc, 32'd8);
    chk("bp_new_prod", bus.prod, 32'd143);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Asynchronous reset at cnt=4.
    start(16'd100, 16'd200);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk1("ar_in_ready", bus.in_ready, 1'b1);
    chk1("ar_out_valid", bus.out_valid, 1'b0);
    chk1("ar_busy", bus.busy, 1'b0);
    chk("ar_prod", bus.prod, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    chk1("ar_no_result", bus.out_valid, 1'b0);
    do_op("ar_m1_m1", 16'hFFFF, 16'hFFFF, 32'h00000001, 0);

    // Clear in DONE with no handshake.
    bus.out_ready = 1'b0;
    start(16'd7, 16'd6);
    wait_done(cyc);
    chk("clr_prod_before", bus.prod, 32'd42);
    hs_before = hs_cnt;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk1("clr_out_valid", bus.out_valid, 1'b0);
    chk1("clr_in_ready", bus.in_ready, 1'b1);
    chk1("clr_busy", bus.busy, 1'b0);
    chk("clr_prod", bus.prod, 32'h0);
    chk("clr_no_hs", hs_cnt, hs_before);

    // Clear mid-CALC, then a clean operation.
    start(16'd50, 16'd60);
    repeat (3) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk1("clr_calc_idle", bus.in_ready, 1'b1);
    do_op("clr_calc_next", 16'hFFFE, 16'd3, 32'hFFFFFFFA, 0);

    // Pseudo-random pairs with random stalls, expected from a signed product.
    for (int k = 0; k < 150; k++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rexp = ra * rb;
      do_op("rand", ra, rb, rexp, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
